// File: rtl/button_event_ctrl.sv
// Per-button press/release/long/repeat event generator feeding a shared event FIFO.
// Each button owns a small FSM and a one-entry pending slot; a round-robin arbiter drains slots into the FIFO.
module button_event_ctrl #(
    parameter int unsigned     NBTN     = 4,
    parameter int unsigned     TW       = 24,
    parameter logic [TW-1:0]   LONG_CYC = 24'd9_500_000,
    parameter logic [TW-1:0]   REP_CYC  = 24'd3_800_000,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [NBTN-1:0]   btn_db,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [1:0]        evt_code,
    output logic [2:0]        evt_id,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic [2*NBTN-1:0] dbg_state
);

    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_RELEASE = 2'b01;
    localparam logic [1:0] EV_LONG    = 2'b10;
    localparam logic [1:0] EV_REPEAT  = 2'b11;

    localparam int unsigned  AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]  DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] LONG_LAST = LONG_CYC - 1'b1;
    localparam logic [TW-1:0] REP_LAST  = REP_CYC - 1'b1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DOWN     = 2'd1,
        S_HOLD     = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    state_t          state_q [NBTN];
    state_t          state_d [NBTN];
    logic [TW-1:0]   timer_q [NBTN];
    logic [TW-1:0]   timer_d [NBTN];
    logic [NBTN-1:0] post;
    logic [1:0]      post_code [NBTN];
    logic [NBTN-1:0] pend_valid;
    logic [1:0]      pend_code [NBTN];

    logic [2:0]      rr_ptr;
    logic [NBTN-1:0] granted;
    logic [2:0]      grant_idx;
    logic [1:0]      grant_code;
    logic            grant_any;
    logic            fifo_wr;
    logic            fifo_rd;
    logic            ovf_set;

    logic [1:0]      mem_code [DEPTH];
    logic [2:0]      mem_id   [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            overflow_q;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
        return (t == '1) ? t : t + 1'b1;
    endfunction

    function automatic logic [2:0] rr_index(input logic [2:0] base, input int unsigned k);
        logic [3:0] s;
        s = {1'b0, base} + 4'(k);
        if (s >= 4'(NBTN)) s = s - 4'(NBTN);
        return s[2:0];
    endfunction

    // Release is tested before timer expiry so a simultaneous expiry posts only RELEASE.
    always_comb begin
        for (int i = 0; i < NBTN; i++) begin
            state_d[i]   = state_q[i];
            timer_d[i]   = timer_q[i];
            post[i]      = 1'b0;
            post_code[i] = EV_PRESS;
            case (state_q[i])
                S_IDLE: if (btn_db[i]) begin
                    state_d[i]   = S_DOWN;
                    timer_d[i]   = '0;
                    post[i]      = 1'b1;
                    post_code[i] = EV_PRESS;
                end
                S_DOWN: if (!btn_db[i]) begin
                    state_d[i]   = S_IDLE;
                    post[i]      = 1'b1;
                    post_code[i] = EV_RELEASE;
                end else if (timer_q[i] == LONG_LAST) begin
                    state_d[i]   = S_HOLD;
                    timer_d[i]   = '0;
                    post[i]      = 1'b1;
                    post_code[i] = EV_LONG;
                end else begin
                    timer_d[i]   = sat_inc(timer_q[i]);
                end
                S_HOLD: if (!btn_db[i]) begin
                    state_d[i]   = S_IDLE;
                    post[i]      = 1'b1;
                    post_code[i] = EV_RELEASE;
                end else if (timer_q[i] == REP_LAST) begin
                    timer_d[i]   = '0;
                    post[i]      = 1'b1;
                    post_code[i] = EV_REPEAT;
                end else begin
                    timer_d[i]   = sat_inc(timer_q[i]);
                end
                default: if (!btn_db[i]) state_d[i] = S_IDLE;
            endcase
        end
    end

    // Buttons already held at reset start in WAIT_REL so no PRESS is reported for them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBTN; i++) begin
            if (!n_reset) begin
                state_q[i] <= btn_db[i] ? S_WAIT_REL : S_IDLE;
                timer_q[i] <= '0;
            end else begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    always_comb begin
        granted    = '0;
        grant_idx  = '0;
        grant_code = EV_PRESS;
        grant_any  = 1'b0;
        for (int k = 0; k < NBTN; k++) begin
            for (int j = 0; j < NBTN; j++) begin
                if (!grant_any && pend_valid[j] && (3'(j) == rr_index(rr_ptr, k))) begin
                    granted[j] = 1'b1;
                    grant_idx  = 3'(j);
                    grant_code = pend_code[j];
                    grant_any  = 1'b1;
                end
            end
        end
        // Fullness is judged on the pre-pop count.
        fifo_wr = grant_any && (count < DEPTH_C);
        if (!fifo_wr) granted = '0;
        ovf_set = |(post & pend_valid & ~granted);
    end

    // A slot being granted this cycle may accept a new post without overflow.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            pend_valid <= '0;
            for (int i = 0; i < NBTN; i++) pend_code[i] <= EV_PRESS;
            rr_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (post[i] && !(pend_valid[i] && !granted[i])) begin
                    pend_valid[i] <= 1'b1;
                    pend_code[i]  <= post_code[i];
                end else if (granted[i]) begin
                    pend_valid[i] <= 1'b0;
                end
            end
            if (fifo_wr) rr_ptr <= (grant_idx == 3'(NBTN-1)) ? 3'd0 : grant_idx + 3'd1;
            if (ovf_set)           overflow_q <= 1'b1;
            else if (clr_overflow) overflow_q <= 1'b0;
        end
    end

    // evt_valid/evt_ready: the head event transfers on a rising edge where both are high;
    // while evt_valid is high and evt_ready low, evt_code/evt_id hold the same head entry.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int d = 0; d < DEPTH; d++) begin
                mem_code[d] <= '0;
                mem_id[d]   <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_wr) begin
                mem_code[wr_ptr] <= grant_code;
                mem_id[wr_ptr]   <= grant_idx;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr, fifo_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign evt_valid = (count != '0);
    assign fifo_rd   = evt_valid & evt_ready;
    assign evt_code  = mem_code[rd_ptr];
    assign evt_id    = mem_id[rd_ptr];
    assign overflow  = overflow_q;

    always_comb begin
        dbg_state = '0;
        for (int i = 0; i < NBTN; i++) dbg_state[2*i +: 2] = state_q[i];
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with short LONG/REPEAT periods; events are
// checked against an expected queue as they are accepted, plus timing checks on the head.
module tb_button_event_ctrl;

    localparam int NBTN = 4;
    localparam int W    = 5;
    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_RELEASE = 2'b01;
    localparam logic [1:0] EV_LONG    = 2'b10;
    localparam logic [1:0] EV_REPEAT  = 2'b11;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_WAIT    = 2'd3;

    logic              clk = 1'b0;
    logic              n_reset = 1'b0;
    logic [NBTN-1:0]   btn_db = '0;
    logic              evt_valid;
    logic              evt_ready = 1'b0;
    logic [1:0]        evt_code;
    logic [2:0]        evt_id;
    logic              overflow;
    logic              clr_overflow = 1'b0;
    logic [2*NBTN-1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sb_exp;

    button_event_ctrl #(
        .NBTN(NBTN), .TW(24), .LONG_CYC(24'd8), .REP_CYC(24'd4), .DEPTH(4)
    ) dut (
        .clk(clk), .n_reset(n_reset), .btn_db(btn_db),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_id(evt_id),
        .overflow(overflow), .clr_overflow(clr_overflow),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic v, input logic [1:0] c, input logic [2:0] id);
        check(tag, 32'({evt_valid, evt_code, evt_id}), 32'({v, c, id}));
    endtask

    task automatic expect_evt(input logic [1:0] c, input logic [2:0] id);
        exp_q.push_back({c, id});
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) wait_cyc(1);
        wait_cyc(2);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // scoreboard: compare each accepted event against the expected queue
    always @(negedge clk) begin
        if (n_reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_extra: observed=%0h expected=none", {evt_code, evt_id});
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_event", 32'({evt_code, evt_id}), 32'(sb_exp));
            end
        end
    end

    initial begin
        int r;
        // reset state
        wait_cyc(3);
        head("reset_head", 1'b0, 2'b00, 3'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        n_reset   = 1'b1;
        evt_ready = 1'b1;
        wait_cyc(2);

        // four simultaneous presses leave in index order on consecutive cycles
        btn_db = 4'hF;
        for (int i = 0; i < 4; i++) expect_evt(EV_PRESS, 3'(i));
        wait_cyc(2);
        head("rr_press0", 1'b1, EV_PRESS, 3'd0);
        wait_cyc(1);
        head("rr_press1", 1'b1, EV_PRESS, 3'd1);
        wait_cyc(1);
        head("rr_press2", 1'b1, EV_PRESS, 3'd2);
        wait_cyc(1);
        head("rr_press3", 1'b1, EV_PRESS, 3'd3);
        btn_db = 4'h0;
        for (int i = 0; i < 4; i++) expect_evt(EV_RELEASE, 3'(i));
        drain("rr_drain");

        // single press/release on button 1 with latency check
        btn_db[1] = 1'b1;
        expect_evt(EV_PRESS, 3'd1);
        wait_cyc(1);
        check("lat_not_early", 32'(evt_valid), 32'd0);
        wait_cyc(1);
        head("press_id1", 1'b1, EV_PRESS, 3'd1);
        r = $urandom_range(1, 4);
        wait_cyc(r);
        btn_db[1] = 1'b0;
        expect_evt(EV_RELEASE, 3'd1);
        wait_cyc(2);
        head("release_id1", 1'b1, EV_RELEASE, 3'd1);
        check("idle_after_rel", 32'(dbg_state[3:2]), 32'(ST_IDLE));
        drain("basic_drain");

        // long press with auto-repeat; release lands on a repeat expiry
        btn_db[0] = 1'b1;
        expect_evt(EV_PRESS, 3'd0);
        expect_evt(EV_LONG, 3'd0);
        expect_evt(EV_REPEAT, 3'd0);
        expect_evt(EV_REPEAT, 3'd0);
        expect_evt(EV_RELEASE, 3'd0);
        wait_cyc(2);
        head("hold_press", 1'b1, EV_PRESS, 3'd0);
        wait_cyc(7);
        check("long_not_early", 32'(evt_valid), 32'd0);
        wait_cyc(1);
        head("hold_long", 1'b1, EV_LONG, 3'd0);
        wait_cyc(4);
        head("hold_rep1", 1'b1, EV_REPEAT, 3'd0);
        check("state_hold", 32'(dbg_state[1:0]), 32'(ST_HOLD));
        wait_cyc(4);
        head("hold_rep2", 1'b1, EV_REPEAT, 3'd0);
        wait_cyc(2);
        btn_db[0] = 1'b0;
        wait_cyc(1);
        check("rel_wins_rep", 32'(evt_valid), 32'd0);
        wait_cyc(1);
        head("hold_release", 1'b1, EV_RELEASE, 3'd0);
        drain("hold_drain");

        // release in the exact cycle the long timer expires
        btn_db[0] = 1'b1;
        expect_evt(EV_PRESS, 3'd0);
        expect_evt(EV_RELEASE, 3'd0);
        wait_cyc(8);
        btn_db[0] = 1'b0;
        wait_cyc(2);
        head("edge_release", 1'b1, EV_RELEASE, 3'd0);
        check("edge_idle", 32'(dbg_state[1:0]), 32'(ST_IDLE));
        drain("edge_drain");

        // backpressure: 4 queued, 1 pending, 1 dropped
        evt_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            btn_db[0] = ~btn_db[0];
            expect_evt((k % 2 == 0) ? EV_PRESS : EV_RELEASE, 3'd0);
            wait_cyc(2);
        end
        check("ovf_before", 32'(overflow), 32'd0);
        head("full_head", 1'b1, EV_PRESS, 3'd0);
        btn_db[0] = 1'b0;
        wait_cyc(1);
        check("ovf_set", 32'(overflow), 32'd1);
        head("full_head_held", 1'b1, EV_PRESS, 3'd0);
        clr_overflow = 1'b1;
        wait_cyc(1);
        clr_overflow = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        evt_ready = 1'b1;
        drain("ovf_drain");
        check("ovf_empty", 32'(evt_valid), 32'd0);

        // mid-operation reset discards queue; button 2 held through reset release
        evt_ready = 1'b0;
        btn_db    = 4'b1100;
        wait_cyc(3);
        check("pre_reset_queued", 32'(evt_valid), 32'd1);
        btn_db  = 4'b0100;
        n_reset = 1'b0;
        wait_cyc(1);
        head("mid_reset_head", 1'b0, 2'b00, 3'd0);
        check("mid_reset_ovf", 32'(overflow), 32'd0);
        check("mid_reset_state", 32'(dbg_state), 32'({ST_IDLE, ST_WAIT, ST_IDLE, ST_IDLE}));
        wait_cyc(2);
        n_reset   = 1'b1;
        evt_ready = 1'b1;
        wait_cyc(4);
        check("held_no_evt", 32'(evt_valid), 32'd0);
        check("held_wait_rel", 32'(dbg_state[5:4]), 32'(ST_WAIT));
        btn_db[2] = 1'b0;
        wait_cyc(2);
        check("wait_rel_no_evt", 32'(evt_valid), 32'd0);
        check("wait_rel_idle", 32'(dbg_state[5:4]), 32'(ST_IDLE));
        btn_db[2] = 1'b1;
        expect_evt(EV_PRESS, 3'd2);
        wait_cyc(2);
        head("repress_id2", 1'b1, EV_PRESS, 3'd2);
        btn_db[2] = 1'b0;
        expect_evt(EV_RELEASE, 3'd2);
        drain("final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 SHALL have parameter NBTN, default 4, number of buttons (2..8).
REQ-002 SHALL have parameter TW, default 24, per-button timer width in bits.
REQ-003 SHALL have parameter LONG_CYC, default 24'd9_500_000, press-to-long-press time in clk cycles (>=2).
REQ-004 SHALL have parameter REP_CYC, default 24'd3_800_000, auto-repeat period in clk cycles (>=2).
REQ-005 SHALL have parameter DEPTH, default 4, event FIFO depth (power of 2).
REQ-006 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port n_reset  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port btn_db  input  NBTN  debounced button levels, 1 = pressed; already synchronous to clk, no resync inside.
REQ-009 SHALL have port evt_valid  output  1  FIFO head event available.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts the head event.
REQ-011 SHALL have port evt_code  output  2  head event type: 00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT.
REQ-012 SHALL have port evt_id  output  3  head event button index.
REQ-013 SHALL have port overflow  output  1  sticky flag: an event was dropped.
REQ-014 SHALL have port clr_overflow  input  1  clears overflow.

Function
REQ-015 SHALL give each button an FSM with states IDLE, DOWN, HOLD and WAIT_REL, a TW-bit timer, and a one-entry pending slot (code plus valid).
REQ-016 SHALL make IDLE with btn=1 go to DOWN, clear the timer, and post PRESS.
REQ-017 SHALL make DOWN with btn=0 go to IDLE and post RELEASE.
REQ-018 SHALL make DOWN with btn=1 and timer==LONG_CYC-1 go to HOLD, clear the timer, and post LONG; otherwise DOWN increments the timer.
REQ-019 SHALL make HOLD with btn=0 go to IDLE and post RELEASE.
REQ-020 SHALL make HOLD with btn=1 and timer==REP_CYC-1 post REPEAT and clear the timer; otherwise HOLD increments the timer.
REQ-021 SHALL make WAIT_REL with btn=0 go to IDLE with no event; WAIT_REL with btn=1 stays in WAIT_REL.
REQ-022 SHALL give release priority over timer expiry when both occur in the same cycle, posting only RELEASE.
REQ-023 SHALL set the pending slot at the FSM transition edge; if the slot is already valid, SHALL drop the new event, keep the old one, and set overflow.
REQ-024 SHALL use a round-robin arbiter to write one pending slot per cycle into the FIFO when the FIFO is not full, searching from the index after the last grant, and clearing the granted slot at the same edge.
REQ-025 SHALL allow a button's slot to be re-posted in the cycle its previous event is granted, with no overflow.
REQ-026 SHALL permit a FIFO write only when count<DEPTH, evaluated before any same-cycle pop.
REQ-027 SHALL pop the FIFO on evt_valid&evt_ready.
REQ-028 SHALL drive evt_valid=(count!=0) from registers.
REQ-029 SHALL hold evt_code and evt_id stable while evt_valid=1 and evt_ready=0.
REQ-030 SHALL give latency for a change first sampled at edge E: slot set at E, FIFO write at E+1, evt_valid=1 after E+1 when the FIFO is empty and there is no competing slot.
REQ-031 SHALL hold the FIFO with no write when full; slots stay pending, and new events on those buttons overflow per REQ-023.
REQ-032 SHALL clear overflow on clr_overflow=1; a same-cycle set wins over clear.
REQ-033 SHALL saturate timers: they never wrap, and expiry is compared on exact equality before increment.

Reset
REQ-034 SHALL, while n_reset=0 at a clk edge, clear all FIFO entries, count, pointers, pending slots, timers, overflow, and the arbiter pointer (next search starts at index 0).
REQ-035 SHALL, during reset, load each FSM with WAIT_REL if btn_db=1, else IDLE; no event is posted for levels present at reset release.
REQ-036 SHALL produce evt_valid=0, evt_code=00, evt_id=0, and overflow=0 from the first edge with n_reset=0.
REQ-037 SHALL make reset mid-operation discard all queued and pending events immediately, with no partial output.

Verification
REQ-038 SHALL cover: btn_db[1] 0->1 at edge E with evt_ready=1 -> evt_valid=1 after E+1 with code 00, id 1; release later -> code 01, id 1.
REQ-039 SHALL cover, with LONG_CYC=8 and REP_CYC=4: hold btn0 for 20 cycles -> PRESS, LONG 8 cycles after PRESS post, REPEAT every 4 cycles, then RELEASE.
REQ-040 SHALL cover: btn0 released in the exact cycle timer==LONG_CYC-1 -> only RELEASE, no LONG.
REQ-041 SHALL cover: btn0..btn3 pressed in the same cycle -> four PRESS events in order id 0,1,2,3 on consecutive cycles.
REQ-042 SHALL cover: evt_ready=0, DEPTH=4, six events generated on one button -> 4 queued, 1 pending, 1 dropped, overflow=1; clr_overflow -> 0.
REQ-043 SHALL cover: btn2 held through reset release -> no event, WAIT_REL; release then press -> only PRESS, id 2.
